// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: the NOP encoding that
// marks an empty IF/ID slot and the fetch-state encoding.
package if_fetch_stage_pkg;

  // addi x0,x0,0 -- architecturally a no-op, used as the bubble instruction
  localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Keeps the PC, issues one memory request at a time,
// and fills the IF/ID pipeline register. A single epoch bit tags each request
// so responses belonging to a path abandoned by an EX redirect are dropped.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        if_id_en,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         epoch_q, epoch_d;
  logic         reqEpoch_q, reqEpoch_d;
  logic [31:0]  holdInst_q, holdInst_d;
  logic [31:0]  ifIr_q, ifIr_d;
  logic [31:0]  ifPc_q, ifPc_d;
  logic [31:0]  ifNpc_q, ifNpc_d;
  logic         ifValid_q, ifValid_d;
  logic [31:0]  pcPlus4;
  logic         reqOutstanding;

  assign pcPlus4 = pc_q + 32'd4;

  // The request strobe comes straight from the state so it is low while in reset
  assign imem_req_valid   = rst && (state_q == FETCH_REQ);
  assign imem_req_addr    = pc_q;
  assign if_id_IR         = ifIr_q;
  assign if_id_PC         = ifPc_q;
  assign if_id_NPC        = ifNpc_q;
  assign if_id_valid_inst = ifValid_q;

  // Next-state, next-PC and IF/ID load decisions; redirect overrides everything
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    epoch_d        = epoch_q;
    reqEpoch_d     = reqEpoch_q;
    holdInst_d     = holdInst_q;
    ifIr_d         = ifIr_q;
    ifPc_d         = ifPc_q;
    ifNpc_d        = ifNpc_q;
    ifValid_d      = ifValid_q;
    reqOutstanding = 1'b0;

    // An enabled IF/ID with nothing new to accept takes a bubble
    if (if_id_en) begin
      ifIr_d    = NOP_INST;
      ifValid_d = 1'b0;
    end

    case (state_q)
      FETCH_REQ: begin
        if (imem_req_ready) begin
          state_d        = FETCH_WAIT;
          reqEpoch_d     = epoch_q;
          reqOutstanding = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          if (reqEpoch_q != epoch_q) begin
            state_d = FETCH_REQ;
          end else if (if_id_en && pc_en) begin
            ifIr_d    = imem_resp_data;
            ifPc_d    = pc_q;
            ifNpc_d   = pcPlus4;
            ifValid_d = 1'b1;
            pc_d      = pcPlus4;
            state_d   = FETCH_REQ;
          end else begin
            holdInst_d = imem_resp_data;
            state_d    = FETCH_HOLD;
          end
        end else begin
          reqOutstanding = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (if_id_en && pc_en) begin
          ifIr_d    = holdInst_q;
          ifPc_d    = pc_q;
          ifNpc_d   = pcPlus4;
          ifValid_d = 1'b1;
          pc_d      = pcPlus4;
          state_d   = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase

    // Tagging any in-flight request with the pre-toggle epoch guarantees a
    // mismatch even after back-to-back redirects with the single epoch bit.
    if (ex_take_branch) begin
      pc_d       = ex_target_pc & 32'hFFFF_FFFC;
      epoch_d    = ~epoch_q;
      reqEpoch_d = epoch_q;
      ifIr_d     = NOP_INST;
      ifPc_d     = ifPc_q;
      ifNpc_d    = ifNpc_q;
      ifValid_d  = 1'b0;
      state_d    = reqOutstanding ? FETCH_WAIT : FETCH_REQ;
    end
  end

  // State, PC, epoch, hold buffer and IF/ID register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH_REQ;
      pc_q       <= RESET_PC;
      epoch_q    <= 1'b0;
      reqEpoch_q <= 1'b0;
      holdInst_q <= 32'd0;
      ifIr_q     <= NOP_INST;
      ifPc_q     <= 32'd0;
      ifNpc_q    <= 32'd0;
      ifValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      reqEpoch_q <= reqEpoch_d;
      holdInst_q <= holdInst_d;
      ifIr_q     <= ifIr_d;
      ifPc_q     <= ifPc_d;
      ifNpc_q    <= ifNpc_d;
      ifValid_q  <= ifValid_d;
    end
  end

endmodule
